// File: rtl/stream_arb2_sel.sv
// Two-input round-robin stream arbiter feeding a 2:1 data mux.
// Drives the mux select, registers the winning beat into a one-entry
// valid/ready output stage, and counts delivered beats per source.
module stream_arb2_sel #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  src_e             last_src_q, last_src_d;
  src_e             out_src_q, out_src_d;
  src_e             grant;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
  logic             load_en;
  logic             accept;
  logic             drain;

  // Round-robin grant: contention goes to the source that did not win last;
  // with no requester the grant parks on the last winner.
  always_comb begin
    grant = last_src_q;
    if (a_valid && b_valid) begin
      grant = (last_src_q == SRC_A) ? SRC_B : SRC_A;
    end else if (a_valid) begin
      grant = SRC_A;
    end else if (b_valid) begin
      grant = SRC_B;
    end
  end

  // Handshake decode: the output stage can load when empty or draining.
  always_comb begin
    load_en = !out_valid_q || out_ready;
    a_ready = load_en && (grant == SRC_A);
    b_ready = load_en && (grant == SRC_B);
    accept  = load_en && ((grant == SRC_A) ? a_valid : b_valid);
    drain   = out_valid_q && out_ready;
  end

  // Next-state for the output stage, arbitration history and counters.
  always_comb begin
    last_src_d  = last_src_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;

    // A new accept takes priority over clearing, so accept+drain keeps valid high.
    if (accept) begin
      out_data_d  = (grant == SRC_A) ? a_data : b_data;
      out_src_d   = grant;
      last_src_d  = grant;
      out_valid_d = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end

    if (drain) begin
      if (out_src_q == SRC_A) begin
        a_cnt_d = a_cnt_q + CNT_W'(1);
      end else begin
        b_cnt_d = b_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset leaves B as last winner so A wins first contention.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      last_src_q  <= SRC_B;
      out_src_q   <= SRC_A;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
    end else begin
      last_src_q  <= last_src_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
    end
  end

  assign sel       = grant;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign a_cnt     = a_cnt_q;
  assign b_cnt     = b_cnt_q;

endmodule

// File: doc/stream_arb2_sel.md
Name: stream_arb2_sel

Overview:
- Two-input round-robin stream arbiter that sits directly upstream of the 2:1 data mux.
- Drives the mux select (`sel`: 0 picks a, 1 picks b) and registers the winning beat into a one-entry output stage with valid/ready handshake.
- Counts delivered beats per source for bench and perf visibility.

Parameters:
- WIDTH, 8, data width of a_data, b_data and out_data.
- CNT_W, 8, width of the per-source delivered-beat counters.

Ports:
- clk  in  1  rising-edge clock
- aresetn  in  1  asynchronous active-low reset
- a_data  in  WIDTH  source A payload
- a_valid  in  1  source A beat present
- a_ready  out  1  source A beat accepted this cycle when a_valid and a_ready are both 1
- b_data  in  WIDTH  source B payload
- b_valid  in  1  source B beat present
- b_ready  out  1  source B beat accepted this cycle when b_valid and b_ready are both 1
- sel  out  1  combinational grant to the downstream mux: 0 = a, 1 = b
- out_data  out  WIDTH  registered payload
- out_valid  out  1  output register holds a beat
- out_src  out  1  source of the held beat: 0 = a, 1 = b
- out_ready  in  1  downstream accepts the beat when out_valid and out_ready are both 1
- a_cnt  out  CNT_W  beats from A delivered downstream
- b_cnt  out  CNT_W  beats from B delivered downstream

Behaviour:
- Reset (aresetn = 0, asynchronous): out_valid = 0, out_data = 0, out_src = 0, a_cnt = 0, b_cnt = 0, internal last_src = 1 (A wins the first contention).
- Reset asserted mid-operation discards any held beat. Nothing is delivered until aresetn is released.
- Grant, combinational each cycle:
  - only a_valid = 1: grant = a.
  - only b_valid = 1: grant = b.
  - both valid: grant = the source not equal to last_src.
  - neither valid: grant holds last_src.
  - sel = grant.
- load_en = !out_valid || out_ready.
- a_ready = load_en && (grant == a). b_ready = load_en && (grant == b).
- At most one of a_ready and b_ready is 1 in any cycle.
- On accept (granted valid && load_en), at the clock edge:
  - out_data <= granted data; out_src <= grant; last_src <= grant; out_valid <= 1.
- If out_valid && out_ready and no accept this cycle: out_valid <= 0. out_data and out_src hold their values.
- Accept and drain in the same cycle: out_valid stays 1 and the new beat replaces the old one. This gives back-to-back throughput of 1 beat per cycle.
- Latency: an input accepted at edge N appears with out_valid = 1 after edge N.
- Stall: while out_valid && !out_ready, out_data, out_src and out_valid hold, and both readies are 0.
- Counters: on each downstream handshake, increment a_cnt if out_src = 0, otherwise b_cnt. Counters wrap modulo 2^CNT_W with no saturation.
- Fairness: under continuous contention with out_ready = 1, grants alternate a, b, a, b, ...
- Protocol rule for upstream: valid must not depend on ready. A source holds its data and valid until accepted.

Test Plan:
- Reset, then a_valid = 1, a_data = 0x11, b_valid = 0, out_ready = 1 -> sel = 0, a_ready = 1; next cycle out_valid = 1, out_data = 0x11, out_src = 0; one cycle later a_cnt = 1.
- Both valid continuously (a_data = 0xA0, b_data = 0xB0), out_ready = 1 for 6 cycles -> out_data sequence 0xA0, 0xB0, 0xA0, 0xB0, ...; out_src alternates 0, 1, 0, 1; a_cnt = 3 and b_cnt = 3 at the end.
- Output stall: hold a beat, out_ready = 0 for 4 cycles with both inputs valid -> a_ready = b_ready = 0, out_data unchanged. Then out_ready = 1 -> the next beat loads in the same cycle with no bubble.
- Idle drain: single beat from B (0x5C), then no inputs and out_ready = 1 -> out_valid is 1 for exactly one cycle, b_cnt = 1; sel stays 1 while idle.
- Assert aresetn = 0 between edges while out_valid = 1 -> out_valid = 0, counters = 0 immediately. After release with both inputs valid, A wins first.
- Counter wrap: deliver 256 A beats with CNT_W = 8 -> a_cnt returns to 0 and b_cnt is unchanged.
